// File: rtl/window_xy_serializer.sv
// Parallel-in/serial-out window unloader: captures two pixel rows, streams pixel NUM_PIX-1 first, pixel 0 last.
// Define WINDOW_SER_DBUF_EN to add a shadow window so back-to-back windows stream without a bubble.
module window_xy_serializer #(
  parameter int PIXEL_WIDTH = 11,
  parameter int NUM_PIX     = 258,
  parameter int CNT_W       = 9
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [PIXEL_WIDTH*NUM_PIX-1:0] lb0_win,
  input  logic [PIXEL_WIDTH*NUM_PIX-1:0] lb1_win,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PIXEL_WIDTH-1:0]         lb0_out,
  output logic [PIXEL_WIDTH-1:0]         lb1_out,
  output logic                           out_last,
  output logic                           busy
);

  localparam int VEC_W = PIXEL_WIDTH * NUM_PIX;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NUM_PIX - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [VEC_W-1:0] lb0_act;
  logic [VEC_W-1:0] lb1_act;
  logic             cnt_zero;
  logic             load_fire;
  logic             beat_fire;
  logic             last_fire;
  logic             load_to_active;
  logic             refill;

`ifdef WINDOW_SER_DBUF_EN
  logic [VEC_W-1:0] lb0_shd;
  logic [VEC_W-1:0] lb1_shd;
  logic             shadow_full;
  logic             load_to_shadow;
`endif

  assign cnt_zero  = (cnt == '0);
  assign load_fire = load_valid && load_ready;
  assign beat_fire = out_valid && out_ready;
  assign last_fire = beat_fire && cnt_zero;

`ifdef WINDOW_SER_DBUF_EN
  // A load landing on the final beat with an empty shadow bypasses the shadow and goes straight to active.
  assign load_to_active = load_fire && ((state == IDLE) || (last_fire && !shadow_full));
  assign load_to_shadow = load_fire && !load_to_active;
  assign refill         = last_fire && shadow_full;
`else
  assign load_to_active = load_fire;
  assign refill         = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_fire) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last_fire && !refill && !load_to_active) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = cnt_zero;
      end
      default: ;
    endcase
`ifdef WINDOW_SER_DBUF_EN
    load_ready = !shadow_full;
`else
    load_ready = (state == IDLE);
`endif
  end

  // The active vectors shift toward the LSB so the LSB slice is always pixel index cnt.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt     <= '0;
      lb0_act <= '0;
      lb1_act <= '0;
    end else if (load_to_active) begin
      cnt     <= CNT_TOP;
      lb0_act <= lb0_win;
      lb1_act <= lb1_win;
`ifdef WINDOW_SER_DBUF_EN
    end else if (refill) begin
      cnt     <= CNT_TOP;
      lb0_act <= lb0_shd;
      lb1_act <= lb1_shd;
`endif
    end else if (beat_fire) begin
      lb0_act <= lb0_act >> PIXEL_WIDTH;
      lb1_act <= lb1_act >> PIXEL_WIDTH;
      if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef WINDOW_SER_DBUF_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      shadow_full <= 1'b0;
      lb0_shd     <= '0;
      lb1_shd     <= '0;
    end else if (load_to_shadow) begin
      shadow_full <= 1'b1;
      lb0_shd     <= lb0_win;
      lb1_shd     <= lb1_win;
    end else if (refill) begin
      shadow_full <= 1'b0;
    end
  end
`endif

  assign lb0_out = lb0_act[PIXEL_WIDTH-1:0];
  assign lb1_out = lb1_act[PIXEL_WIDTH-1:0];

endmodule

// File: tb/tb_window_xy_serializer.sv
// Bench for window_xy_serializer: a queue-of-pixel-pairs model predicts every output each cycle.
module tb_window_xy_serializer;
  localparam int PW = 11;
  localparam int NP = 258;
  localparam int VW = PW * NP;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] win0 = '0;
  logic [VW-1:0] win1 = '0;
  logic          load_ready;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic [PW-1:0] lb0_out;
  logic [PW-1:0] lb1_out;

  logic [2*PW-1:0] q[$];
  logic [2*PW-1:0] sq[$];
  logic [2*PW-1:0] win_q[$];
  logic [PW-1:0]   p0[NP];
  logic [PW-1:0]   p1[NP];
  logic [VW-1:0]   sr0;
  logic [VW-1:0]   sr1;
  int              total = 0;
  int              bad = 0;
  int              hs = 0;
  int              lasts = 0;
  logic            accepted;

  window_xy_serializer #(.PIXEL_WIDTH(PW), .NUM_PIX(NP), .CNT_W(9)) dut (
    .clock(clock), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .lb0_win(win0), .lb1_win(win1), .out_valid(out_valid), .out_ready(out_ready),
    .lb0_out(lb0_out), .lb1_out(lb1_out), .out_last(out_last), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference window shift register: shifts in at the MSB, so pixel 0 (last beat) lands in the MSB slice.
  always @(posedge clock) begin
    if (out_valid && out_ready) begin
      sr0 <= {lb0_out, sr0[VW-1:PW]};
      sr1 <= {lb1_out, sr1[VW-1:PW]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic modelLoadReady();
`ifdef WINDOW_SER_DBUF_EN
    return sq.size() == 0;
`else
    return q.size() == 0;
`endif
  endfunction

  task automatic makeWindow(input int mode);
    for (int i = 0; i < NP; i++) begin
      p0[i] = (mode == 0) ? PW'(i) : PW'($urandom);
      p1[i] = (mode == 0) ? PW'(1000 - i) : PW'($urandom);
      win0[(NP-1-i)*PW +: PW] = p0[i];
      win1[(NP-1-i)*PW +: PW] = p1[i];
    end
    win_q.delete();
    for (int i = NP - 1; i >= 0; i--) win_q.push_back({p0[i], p1[i]});
  endtask

  task automatic checkAll();
    checkOutput("out_valid", out_valid, q.size() != 0);
    checkOutput("busy", busy, q.size() != 0);
    checkOutput("load_ready", load_ready, modelLoadReady());
    checkOutput("out_last", out_last, q.size() == 1);
    if (q.size() != 0) begin
      checkOutput("lb0_out", lb0_out, q[0][2*PW-1:PW]);
      checkOutput("lb1_out", lb1_out, q[0][PW-1:0]);
    end
  endtask

  // One clock: drive inputs, predict the edge from the model, then compare after the edge.
  task automatic applyStimulus(input logic lv, input logic ordy, input logic r);
    logic do_beat;
    logic do_load;
    load_valid = lv;
    out_ready  = ordy;
    rst        = r;
    do_beat    = !r && (q.size() != 0) && ordy;
    do_load    = !r && lv && modelLoadReady();
    if (do_beat) hs++;
    if (do_beat && out_last) lasts++;
    @(posedge clock);
    #1;
    accepted = do_load;
    if (r) begin
      q.delete();
      sq.delete();
    end else begin
      if (do_beat) void'(q.pop_front());
`ifdef WINDOW_SER_DBUF_EN
      if (do_beat && q.size() == 0 && sq.size() != 0) begin
        q = sq;
        sq.delete();
      end
`endif
      if (do_load) begin
        if (q.size() == 0) q = win_q;
        else sq = win_q;
      end
    end
    checkAll();
  endtask

  task automatic runUntilIdle(input int duty);
    int guard = 0;
    while (q.size() != 0 && guard < 20000) begin
      applyStimulus(1'b0, $urandom_range(0, 99) < duty, 1'b0);
      guard++;
    end
    checkOutput("drain_bound", guard < 20000, 1);
  endtask

  initial begin
    int guard;
    int cyc;
    logic pend;

    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rst_lb0", lb0_out, 0);
    checkOutput("rst_lb1", lb1_out, 0);

    $display("[TB] ramp window, out_ready high");
    makeWindow(0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("first_lb0", lb0_out, 257);
    checkOutput("first_lb1", lb1_out, 743);
    guard = 0;
    while (q.size() > 1 && guard < 1000) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("last_lb0", lb0_out, 0);
    checkOutput("last_lb1", lb1_out, 1000);
    checkOutput("last_flag", out_last, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ready_after_last", load_ready, 1);
    checkOutput("rebuild_row0", sr0 == win0, 1);
    checkOutput("rebuild_row1", sr1 == win1, 1);

    $display("[TB] random windows, 30%% out_ready, load held during send");
    makeWindow(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    makeWindow(1);
    hs = 0;
    pend = 1'b1;
    guard = 0;
    while ((pend || q.size() != 0) && guard < 20000) begin
      applyStimulus(pend, $urandom_range(0, 99) < 30, 1'b0);
      if (accepted) pend = 1'b0;
      guard++;
    end
    checkOutput("stall_handshakes", hs, 2 * NP);

    $display("[TB] reset at beat 100");
    makeWindow(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", load_ready, 1);
    makeWindow(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart_lb0", lb0_out, p0[NP-1]);
    checkOutput("restart_lb1", lb1_out, p1[NP-1]);
    runUntilIdle(60);

    $display("[TB] back-to-back windows");
    makeWindow(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    makeWindow(1);
    pend = 1'b1;
    cyc = 0;
    lasts = 0;
    hs = 0;
    while ((pend || q.size() != 0) && cyc < 5000) begin
      applyStimulus(pend, 1'b1, 1'b0);
      if (accepted) pend = 1'b0;
      cyc++;
    end
    checkOutput("b2b_handshakes", hs, 2 * NP);
    checkOutput("b2b_lasts", lasts, 2);
`ifdef WINDOW_SER_DBUF_EN
    checkOutput("b2b_cycles", cyc, 2 * NP);
`else
    checkOutput("b2b_cycles", cyc, 2 * NP + 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
